sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_pos_cnt.sv | 61 ++++++
 rtl/sobel_frame_ctrl.sv | 113 +++++++++++
 tb/tb_sobel_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sobel_pkg : shared defaults, FSM encoding, width helper  rev 1.0 |
// +------------------------------------------------------------------+
package sobel_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int OUT_W     = 32;

  typedef enum logic [1:0] {
    ST_ACCEPT   = 2'd0,
    ST_WAIT_RES = 2'd1,
    ST_EMIT_GX  = 2'd2,
    ST_EMIT_GY  = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_pos_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sobel_pos_cnt : raster row/col position with window flags rev 1.0|
// +------------------------------------------------------------------+
module sobel_pos_cnt
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic last_o,
  output logic win_o
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_end, row_end;

  assign col_end = (col_q == COL_MAX);
  assign row_end = (row_q == ROW_MAX);
  // Flags describe the pixel currently being offered, before it advances.
  assign last_o  = col_end && row_end;
  assign win_o   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sobel_frame_ctrl : AXIS pixel-in / gradient-out frame FSM rev 1.0|
// +------------------------------------------------------------------+
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             S_AXIS_TVALID,
  input  logic [31:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic             PIX_WE,
  output logic [7:0]       PIX_DATA,
  output logic             WIN_VALID,
  input  logic             RES_VALID,
  input  logic [7:0]       GX,
  input  logic [7:0]       GY,
  output logic             M_AXIS_TVALID,
  output logic [OUT_W-1:0] M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  output logic             FRAME_DONE,
  output logic             FRAME_ERR
);

  state_e     state_q, state_d;
  logic       in_hs, cnt_clr, pos_last, pos_win;
  logic       pix_we_q, win_valid_q, last_win_q, frame_done_q, frame_err_q;
  logic [7:0] pix_data_q, gx_q, gy_q;
  logic       unused_tdata;

  assign unused_tdata = ^S_AXIS_TDATA[31:8];
  assign in_hs        = S_AXIS_TVALID && S_AXIS_TREADY;
  // Early TLAST restarts the raster so the next pixel is (0,0).
  assign cnt_clr      = in_hs && S_AXIS_TLAST && !pos_last;

  sobel_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .en_i   (in_hs),
    .clr_i  (cnt_clr),
    .last_o (pos_last),
    .win_o  (pos_win)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_ACCEPT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = {24'b0, gx_q};
    M_AXIS_TLAST  = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        S_AXIS_TREADY = !ARESET;
        if (S_AXIS_TVALID && !ARESET && pos_win) state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: if (RES_VALID) state_d = ST_EMIT_GX;
      ST_EMIT_GX: begin
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) state_d = ST_EMIT_GY;
      end
      ST_EMIT_GY: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = {24'b0, gy_q};
        M_AXIS_TLAST  = last_win_q;
        if (M_AXIS_TREADY) state_d = ST_ACCEPT;
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pix_we_q     <= 1'b0;
      win_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      last_win_q   <= 1'b0;
      gx_q         <= '0;
      gy_q         <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      pix_we_q     <= in_hs;
      win_valid_q  <= in_hs && pos_win;
      frame_done_q <= (state_q == ST_EMIT_GY) && M_AXIS_TREADY && last_win_q;
      if (in_hs) pix_data_q <= S_AXIS_TDATA[7:0];
      if (in_hs && pos_win) last_win_q <= pos_last;
      if ((state_q == ST_WAIT_RES) && RES_VALID) begin
        gx_q <= GX;
        gy_q <= GY;
      end
      if (in_hs && (S_AXIS_TLAST != pos_last)) frame_err_q <= 1'b1;
    end
  end

  assign PIX_WE     = pix_we_q;
  assign PIX_DATA   = pix_data_q;
  assign WIN_VALID  = win_valid_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_ERR  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sobel_frame_ctrl : scoreboard bench on a 6x5 frame    rev 1.0 |
// +------------------------------------------------------------------+
module tb_sobel_frame_ctrl;

  localparam int W      = 6;
  localparam int H      = 5;
  localparam int NPIX   = W * H;
  localparam int NWORDS = 2 * (W - 2) * (H - 2);

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        S_AXIS_TVALID = 1'b0;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TREADY;
  logic        PIX_WE;
  logic [7:0]  PIX_DATA;
  logic        WIN_VALID;
  logic        RES_VALID = 1'b0;
  logic [7:0]  GX = '0;
  logic [7:0]  GY = '0;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b1;
  logic        FRAME_DONE;
  logic        FRAME_ERR;

  always #5 ACLK = ~ACLK;

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H)) u_dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .PIX_WE        (PIX_WE),
    .PIX_DATA      (PIX_DATA),
    .WIN_VALID     (WIN_VALID),
    .RES_VALID     (RES_VALID),
    .GX            (GX),
    .GY            (GY),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .FRAME_DONE    (FRAME_DONE),
    .FRAME_ERR     (FRAME_ERR)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb[$];   // {tlast, byte}
  int   lat = 1;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  bit   spur_en = 1'b0;
  bit   pend = 1'b0;
  int   cnt = 0;
  logic [7:0] hold = '0;
  bit   stalled = 1'b0;
  logic [31:0] st_data = '0;
  logic st_last = 1'b0;
  bit   done_exp = 1'b0;
  int   n_words = 0, n_tlast = 0, n_done = 0, n_pixwe = 0;
  int   pr = 0, pc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Datapath stand-in, downstream ready generator and output monitor.
  always @(negedge ACLK) begin
    logic [8:0] e;
    case (rdy_mode)
      0:       M_AXIS_TREADY = 1'b1;
      1:       M_AXIS_TREADY = 1'($urandom_range(1, 0));
      default: M_AXIS_TREADY = 1'b0;
    endcase
    RES_VALID = 1'b0;
    if (WIN_VALID === 1'b1) begin
      pend = 1'b1;
      cnt  = lat - 1;
      hold = PIX_DATA;
    end
    if (ARESET) pend = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        RES_VALID = 1'b1;
        GX   = hold ^ 8'h5A;
        GY   = hold + 8'd17;
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end else if (spur_en && ($urandom_range(2, 0) == 0)) begin
      RES_VALID = 1'b1;
      GX = 8'hEE;
      GY = 8'hDD;
    end

    if (!ARESET) begin
      if (stalled) begin
        chk("stall_tvalid", M_AXIS_TVALID, 1'b1);
        chk("stall_tdata", M_AXIS_TDATA, st_data);
        chk("stall_tlast", M_AXIS_TLAST, st_last);
      end
      if (done_exp || FRAME_DONE) chk("frame_done", FRAME_DONE, done_exp);
      done_exp = 1'b0;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        n_words++;
        if (M_AXIS_TLAST) n_tlast++;
        if (sb.size() == 0) begin
          chk("unexpected_word", M_AXIS_TDATA, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("tdata", M_AXIS_TDATA, {24'h0, e[7:0]});
          chk("tlast", M_AXIS_TLAST, e[8]);
          done_exp = e[8];
        end
      end
      stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
      st_data = M_AXIS_TDATA;
      st_last = M_AXIS_TLAST;
    end else begin
      stalled  = 1'b0;
      done_exp = 1'b0;
    end
    if (FRAME_DONE === 1'b1) n_done++;
    if (PIX_WE === 1'b1) n_pixwe++;
  end

  task automatic send_px(input logic [7:0] d, input logic last, input logic win);
    int to = 0;
    logic [31:0] r = $urandom();
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = {r[23:0], d};
    S_AXIS_TLAST  = last;
    while (S_AXIS_TREADY !== 1'b1 && to < 500) begin
      @(negedge ACLK);
      to++;
    end
    if (to >= 500) chk("in_timeout", 32'd1, 32'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    chk("pix_we", PIX_WE, 1'b1);
    chk("pix_data", PIX_DATA, d);
    chk("win_valid", WIN_VALID, win);
  endtask

  task automatic send_frame(input int base, input int npix, input int tlast_idx);
    for (int i = 0; i < npix; i++) begin
      logic [7:0] d = 8'((base + i) % 256);
      logic [7:0] gy = d + 8'd17;
      logic last = (i == tlast_idx);
      logic win = (pr >= 2) && (pc >= 2);
      logic endpos = (pr == H - 1) && (pc == W - 1);
      if (win) begin
        sb.push_back({1'b0, d ^ 8'h5A});
        sb.push_back({endpos, gy});
      end
      send_px(d, last, win);
      if ((last && !endpos) || endpos) begin
        pr = 0;
        pc = 0;
      end else if (pc == W - 1) begin
        pc = 0;
        pr++;
      end else begin
        pc++;
      end
    end
  endtask

  task automatic run_frame(input int base, input int npix, input int tlast_idx,
                           input int expw, input int expt, input logic exp_err);
    int w0 = n_words, t0 = n_tlast, d0 = n_done, p0 = n_pixwe, to = 0;
    send_frame(base, npix, tlast_idx);
    while (sb.size() != 0 && to < 3000) begin
      @(negedge ACLK);
      to++;
    end
    chk("drain_left", sb.size(), 0);
    repeat (4) @(negedge ACLK);
    chk("word_count", n_words - w0, expw);
    chk("tlast_count", n_tlast - t0, expt);
    chk("done_count", n_done - d0, expt);
    chk("pix_we_count", n_pixwe - p0, npix);
    chk("frame_err", FRAME_ERR, exp_err);
  endtask

  task automatic check_reset();
    chk("rst_s_tready", S_AXIS_TREADY, 1'b0);
    chk("rst_m_tvalid", M_AXIS_TVALID, 1'b0);
    chk("rst_m_tdata", M_AXIS_TDATA, 32'h0);
    chk("rst_m_tlast", M_AXIS_TLAST, 1'b0);
    chk("rst_pix_we", PIX_WE, 1'b0);
    chk("rst_pix_data", PIX_DATA, 8'h0);
    chk("rst_win_valid", WIN_VALID, 1'b0);
    chk("rst_frame_done", FRAME_DONE, 1'b0);
    chk("rst_frame_err", FRAME_ERR, 1'b0);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    check_reset();
    sb.delete();
    pr = 0;
    pc = 0;
    ARESET = 1'b0;
    #1;
    chk("tready_after_reset", S_AXIS_TREADY, 1'b1);
    @(negedge ACLK);
  endtask

  initial begin
    int to;
    do_reset();

    // Ramp frame, latency 1, always ready.
    run_frame(0, NPIX, NPIX - 1, NWORDS, 1, 1'b0);

    // Same frame, latency 5, random stalls, stray results between windows.
    lat = 5; rdy_mode = 1; spur_en = 1'b1;
    run_frame(0, NPIX, NPIX - 1, NWORDS, 1, 1'b0);

    // Missing TLAST on the last pixel: frame still completes, error latches.
    lat = 2;
    run_frame(40, NPIX, -1, NWORDS, 1, 1'b1);
    run_frame(7, NPIX, NPIX - 1, NWORDS, 1, 1'b1);
    do_reset();

    // Early TLAST on pixel 17 (row 2, col 5): four windows, no output TLAST.
    run_frame(100, 18, 17, 8, 0, 1'b1);
    run_frame(50, NPIX, NPIX - 1, NWORDS, 1, 1'b1);
    do_reset();

    // Reset while stalled in the first GX word.
    lat = 1; rdy_mode = 2; spur_en = 1'b0;
    send_frame(0, 15, -1);
    to = 0;
    while (M_AXIS_TVALID !== 1'b1 && to < 50) begin
      @(negedge ACLK);
      to++;
    end
    chk("emit_gx_valid", M_AXIS_TVALID, 1'b1);
    chk("emit_gx_data", M_AXIS_TDATA, {24'h0, 8'd14 ^ 8'h5A});
    chk("emit_gx_tlast", M_AXIS_TLAST, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    check_reset();
    sb.delete();
    pr = 0;
    pc = 0;
    rdy_mode = 0;
    ARESET = 1'b0;
    @(negedge ACLK);
    run_frame(3, NPIX, NPIX - 1, NWORDS, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
